// File: rtl/fx_gen_pkg.sv
// rtl/fx_gen_pkg.sv - shared constants for the clk_fx test-signal generator
package fx_gen_pkg;

   localparam int FX_ACC_W  = 32;
   localparam int FX_DUTY_W = 8;

   // generator states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // power-up configuration: 781250 Hz at 50 MHz, 50 % duty
   localparam logic [FX_ACC_W-1:0]  FTW_RST  = 32'h0400_0000;
   localparam logic [FX_DUTY_W-1:0] DUTY_RST = 8'h80;

endpackage

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - registered phase accumulator with sync clear and carry-out
module phase_acc
   import fx_gen_pkg::*;
#(
   parameter int ACC_W = FX_ACC_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [ACC_W-1:0] ftw,
   output logic [ACC_W-1:0] next_phase,
   output logic             wrap
);

   logic [ACC_W-1:0] phase_q;
   logic [ACC_W-1:0] phase_d;

   // next phase and carry-out; the carry marks the end of one output period
   always_comb begin
      {wrap, next_phase} = {1'b0, phase_q} + {1'b0, ftw};
   end

   // clear wins over advance so a start or abort always restarts from phase 0
   always_comb begin
      phase_d = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (en) begin
         phase_d = next_phase;
      end
   end

   // phase register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/fx_signal_gen.sv
// rtl/fx_signal_gen.sv - programmable square-wave / burst generator driving clk_fx
module fx_signal_gen
   import fx_gen_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int ACC_W    = FX_ACC_W,
   parameter int DUTY_W   = FX_DUTY_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ACC_W-1:0]  cfg_ftw,
   input  logic [DUTY_W-1:0] cfg_duty,
   input  logic [15:0]       cfg_burst,
   input  logic              start,
   input  logic              stop,
   output logic              clk_fx_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       period_cnt
);

   // CLK_FREQ only documents f_out = ftw * CLK_FREQ / 2^ACC_W
   if (CLK_FREQ <= 0) begin : g_clk_freq_check
      $error("fx_signal_gen: CLK_FREQ must be positive");
   end

   logic [1:0]        state_q, state_d;
   logic [ACC_W-1:0]  ftw_q, ftw_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [15:0]       burst_q, burst_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              clk_fx_q, clk_fx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cfg_ready_q, cfg_ready_d;

   logic              cfg_take;
   logic              acc_clr;
   logic              acc_en;
   logic [ACC_W-1:0]  acc_next;
   logic              acc_wrap;
   logic [15:0]       cnt_inc;

   assign cfg_take = cfg_valid && cfg_ready_q;
   assign cnt_inc  = cnt_q + 16'd1;

   phase_acc #(
      .ACC_W (ACC_W)
   ) u_phase_acc (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .clr        (acc_clr),
      .en         (acc_en),
      .ftw        (ftw_q),
      .next_phase (acc_next),
      .wrap       (acc_wrap)
   );

   // config capture, state sequencing, period counting and output level
   always_comb begin
      state_d  = state_q;
      ftw_d    = ftw_q;
      duty_d   = duty_q;
      burst_d  = burst_q;
      cnt_d    = cnt_q;
      clk_fx_d = clk_fx_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;

      // a config taken together with start is what that start runs with
      if (cfg_take) begin
         ftw_d   = cfg_ftw;
         duty_d  = cfg_duty;
         burst_d = cfg_burst;
      end

      case (state_q)
         ST_RUN: begin
            if (stop) begin
               // abort beats a coinciding wrap or burst end: no done, count frozen
               state_d  = ST_IDLE;
               clk_fx_d = 1'b0;
               acc_clr  = 1'b1;
            end else begin
               acc_en   = 1'b1;
               clk_fx_d = (acc_next[ACC_W-1 -: DUTY_W] < duty_q);
               if (acc_wrap) begin
                  if (cnt_q != 16'hFFFF) begin
                     cnt_d = cnt_inc;
                  end
                  if ((burst_q != 16'd0) && (cnt_inc == burst_q)) begin
                     state_d  = ST_DONE;
                     clk_fx_d = 1'b0;
                     acc_clr  = 1'b1;
                     done_d   = 1'b1;
                  end
               end
            end
         end
         default: begin
            // IDLE and DONE behave alike; stop masks a simultaneous start
            if (!stop && start) begin
               if (ftw_d != '0) begin
                  state_d  = ST_RUN;
                  acc_clr  = 1'b1;
                  cnt_d    = 16'd0;
                  clk_fx_d = (duty_d != '0);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      endcase

      busy_d      = (state_d == ST_RUN);
      cfg_ready_d = (state_d != ST_RUN);
   end

   // all state and outputs come straight from flops so clk_fx_out is glitch-free
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         ftw_q       <= ACC_W'(FTW_RST);
         duty_q      <= DUTY_W'(DUTY_RST);
         burst_q     <= 16'd0;
         cnt_q       <= 16'd0;
         clk_fx_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         ftw_q       <= ftw_d;
         duty_q      <= duty_d;
         burst_q     <= burst_d;
         cnt_q       <= cnt_d;
         clk_fx_q    <= clk_fx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready  = cfg_ready_q;
   assign clk_fx_out = clk_fx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign period_cnt = cnt_q;

endmodule

// File: tb/tb_fx_signal_gen.sv
// tb/tb_fx_signal_gen.sv - self-checking bench for fx_signal_gen
module tb_fx_signal_gen;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_ftw;
   logic [7:0]  cfg_duty;
   logic [15:0] cfg_burst;
   logic        start;
   logic        stop;
   logic        clk_fx_out;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] period_cnt;

   int n_run  = 0;
   int n_fail = 0;

   fx_signal_gen dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ftw    (cfg_ftw),
      .cfg_duty   (cfg_duty),
      .cfg_burst  (cfg_burst),
      .start      (start),
      .stop       (stop),
      .clk_fx_out (clk_fx_out),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .period_cnt (period_cnt)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_clk"},   clk_fx_out, 0);
      check({tag, "_busy"},  busy,       0);
      check({tag, "_done"},  done,       0);
      check({tag, "_err"},   err,        0);
      check({tag, "_cnt"},   period_cnt, 0);
      check({tag, "_ready"}, cfg_ready,  1);
   endtask

   // Starts a run and checks every cycle against the closed form:
   // k cycles after start the phase is k*f mod 2^32, the completed periods are
   // floor(k*f / 2^32), the output is high while the top phase byte is below d,
   // and a burst of b ends on the first k whose completed periods reach b.
   task automatic run_gen(input logic [31:0] f, input logic [7:0] d, input logic [15:0] b,
                          input bit load, input bit offer, input int stop_k,
                          output int n_rise, output int n_high, output int done_k);
      longint unsigned p;
      longint unsigned wraps;
      logic [15:0]     exp_cnt;
      bit              prev;
      n_rise = 0;
      n_high = 0;
      done_k = -1;
      prev   = 1'b0;
      if (load) begin
         cfg_ftw   = f;
         cfg_duty  = d;
         cfg_burst = b;
         cfg_valid = 1'b1;
      end else begin
         cfg_valid = 1'b0;
      end
      start = 1'b1;
      step();
      start     = 1'b0;
      cfg_valid = load ? 1'b0 : offer;
      for (int k = 0; k <= stop_k; k++) begin
         p     = 64'(k) * {32'd0, f};
         wraps = p >> 32;
         if ((b != 16'd0) && (wraps >= {48'd0, b})) begin
            done_k = k;
            check("done_pulse", done,       1);
            check("done_busy",  busy,       0);
            check("done_clk",   clk_fx_out, 0);
            check("done_cnt",   period_cnt, b);
            check("done_ready", cfg_ready,  1);
            step();
            cfg_valid = 1'b0;
            check("done_once",  done,       0);
            check("after_clk",  clk_fx_out, 0);
            check("after_cnt",  period_cnt, b);
            return;
         end
         exp_cnt = (wraps > 64'hFFFF) ? 16'hFFFF : wraps[15:0];
         check("run_clk",   clk_fx_out, (p[31:24] < d));
         check("run_busy",  busy,       1);
         check("run_done",  done,       0);
         check("run_err",   err,        0);
         check("run_ready", cfg_ready,  0);
         check("run_cnt",   period_cnt, exp_cnt);
         if (clk_fx_out && !prev) n_rise++;
         if (clk_fx_out) n_high++;
         prev = clk_fx_out;
         if (k == stop_k) begin
            stop = 1'b1;
            step();
            stop      = 1'b0;
            cfg_valid = 1'b0;
            check("stop_busy",  busy,       0);
            check("stop_clk",   clk_fx_out, 0);
            check("stop_done",  done,       0);
            check("stop_cnt",   period_cnt, exp_cnt);
            check("stop_ready", cfg_ready,  1);
            return;
         end
         step();
      end
   endtask

   initial begin
      int rise, high, dk;
      logic [31:0] rf;
      logic [7:0]  rd;
      logic [15:0] rb;

      sys_rst_n = 1'b0;
      cfg_valid = 1'b0;
      cfg_ftw   = '0;
      cfg_duty  = '0;
      cfg_burst = '0;
      start     = 1'b0;
      stop      = 1'b0;
      repeat (3) step();
      check_reset_vals("in_reset");
      sys_rst_n = 1'b1;
      step();
      check_reset_vals("post_reset");

      // reset-default config: 64-cycle period, 32 high, continuous
      run_gen(32'h0400_0000, 8'h80, 16'd0, 1'b0, 1'b0, 191, rise, high, dk);
      check("dflt_rises", rise, 3);
      check("dflt_highs", high, 96);

      // five-period burst at 25 % duty
      run_gen(32'h0400_0000, 8'h40, 16'd5, 1'b1, 1'b0, 1000, rise, high, dk);
      check("burst_done_k", dk,   320);
      check("burst_rises",  rise, 5);
      check("burst_highs",  high, 80);

      // zero tuning word is rejected
      cfg_ftw   = 32'd0;
      cfg_duty  = 8'h80;
      cfg_burst = 16'd0;
      cfg_valid = 1'b1;
      start     = 1'b1;
      step();
      start     = 1'b0;
      cfg_valid = 1'b0;
      check("err_pulse", err,        1);
      check("err_busy",  busy,       0);
      check("err_clk",   clk_fx_out, 0);
      step();
      check("err_once",  err,        0);
      check("err_busy2", busy,       0);

      // start and stop together while idle: stop wins
      cfg_ftw   = 32'h0400_0000;
      cfg_valid = 1'b1;
      start     = 1'b1;
      stop      = 1'b1;
      step();
      start     = 1'b0;
      stop      = 1'b0;
      cfg_valid = 1'b0;
      check("ss_busy", busy,       0);
      check("ss_err",  err,        0);
      check("ss_clk",  clk_fx_out, 0);

      // stop lands on the final wrap of a two-period burst
      run_gen(32'h0400_0000, 8'h80, 16'd2, 1'b1, 1'b0, 127, rise, high, dk);
      check("stopwrap_nodone", dk, -1);
      step();
      check("stopwrap_done2", done, 0);

      // offer held during a run is ignored, then taken once the burst is done
      cfg_ftw   = 32'h0400_0000;
      cfg_duty  = 8'h80;
      cfg_burst = 16'd2;
      cfg_valid = 1'b1;
      step();
      cfg_ftw   = 32'h0800_0000;
      cfg_burst = 16'd3;
      run_gen(32'h0400_0000, 8'h80, 16'd2, 1'b0, 1'b1, 1000, rise, high, dk);
      check("offer_old_done_k", dk, 128);
      run_gen(32'h0800_0000, 8'h80, 16'd3, 1'b0, 1'b0, 1000, rise, high, dk);
      check("offer_new_done_k", dk,   96);
      check("offer_new_highs",  high, 48);

      // zero duty: no high time, periods still counted
      run_gen(32'h0800_0000, 8'h00, 16'd2, 1'b1, 1'b0, 1000, rise, high, dk);
      check("duty0_highs",  high, 0);
      check("duty0_done_k", dk,   64);

      // asynchronous reset in the middle of a burst
      cfg_ftw   = 32'h0200_0000;
      cfg_duty  = 8'h33;
      cfg_burst = 16'd7;
      cfg_valid = 1'b1;
      start     = 1'b1;
      step();
      start     = 1'b0;
      cfg_valid = 1'b0;
      repeat (100) step();
      check("mid_busy", busy, 1);
      #3;
      sys_rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      step();
      sys_rst_n = 1'b1;
      run_gen(32'h0400_0000, 8'h80, 16'd0, 1'b0, 1'b0, 130, rise, high, dk);
      check("rst_rises", rise, 3);

      // randomized configs, each loaded in the same cycle as its start
      for (int i = 0; i < 8; i++) begin
         rf = $urandom_range(32'h0200_0000, 32'h4000_0000);
         case ($urandom_range(0, 3))
            0:       rd = 8'h00;
            1:       rd = 8'hFF;
            default: rd = 8'($urandom_range(0, 255));
         endcase
         rb = 16'($urandom_range(0, 4));
         run_gen(rf, rd, rb, 1'b1, 1'b0, $urandom_range(20, 400), rise, high, dk);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
